// File: rtl/data_memory_pkg.sv
// Shared definitions for the RV32I data memory stage: width and the DMCtrl (funct3) encodings.
package data_memory_pkg;

    localparam int XLEN = 32;

    // DMCtrl values, taken directly from funct3 of loads and stores
    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    // Unsigned widths only exist for loads; a store using them is illegal
    function automatic logic is_legal_dmctrl(input logic [2:0] ctrl, input logic is_store);
        logic ok;
        case (ctrl)
            DM_B, DM_H, DM_W: ok = 1'b1;
            DM_BU, DM_HU:     ok = ~is_store;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_memory_load_align.sv
// Load data formatting: picks the byte/half lane out of the addressed word and extends it.
module dm_load_align
    import data_memory_pkg::*;
(
    input  logic [XLEN-1:0] word_in,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      dmctrl,
    input  logic            access_ok,
    output logic [XLEN-1:0] data_rd
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select, then sign/zero extension; anything faulty reads as zero
    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = word_in[7:0];
            2'd1:    byte_sel = word_in[15:8];
            2'd2:    byte_sel = word_in[23:16];
            default: byte_sel = word_in[31:24];
        endcase
        half_sel = addr_lo[1] ? word_in[31:16] : word_in[15:0];

        data_rd = '0;
        if (access_ok) begin
            case (dmctrl)
                DM_B:    data_rd = {{24{byte_sel[7]}}, byte_sel};
                DM_BU:   data_rd = {24'd0, byte_sel};
                DM_H:    data_rd = {{16{half_sel[15]}}, half_sel};
                DM_HU:   data_rd = {16'd0, half_sel};
                DM_W:    data_rd = word_in;
                default: data_rd = '0;
            endcase
        end
    end

endmodule

// File: rtl/data_memory.sv
// Data memory stage: word-organised little-endian storage, byte-enable store merge,
// combinational load path, alignment/legality fault with a sticky debug flag.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    input  logic        DMWr,
    input  logic        DMRd,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] DataRd,
    output logic        Fault,
    output logic        FaultSticky
);

    localparam int ADDR_BITS = $clog2(DEPTH_WORDS);

    logic [XLEN-1:0]      mem_q [DEPTH_WORDS];
    logic [ADDR_BITS-1:0] word_idx;
    logic [XLEN-1:0]      rd_word;
    logic [XLEN-1:0]      wr_data;
    logic [XLEN-1:0]      wr_word_d;
    logic [3:0]           byte_en;
    logic                 legal;
    logic                 misaligned;
    logic                 access_ok;
    logic                 wr_en;
    logic                 fault_sticky_d;
    logic                 fault_sticky_q;
    logic                 unused_addr_hi;

    // Upper address bits are ignored so accesses wrap around the array
    assign word_idx       = Address[ADDR_BITS+1:2];
    assign unused_addr_hi = ^Address[31:ADDR_BITS+2];
    assign rd_word        = mem_q[word_idx];

    // Legality and alignment; the store rules apply whenever DMWr is high
    always_comb begin
        legal      = is_legal_dmctrl(DMCtrl, DMWr);
        misaligned = 1'b0;
        case (DMCtrl)
            DM_H, DM_HU: misaligned = Address[0];
            DM_W:        misaligned = |Address[1:0];
            default:     misaligned = 1'b0;
        endcase
        access_ok      = legal & ~misaligned;
        Fault          = ~access_ok & (DMWr | DMRd);
        wr_en          = DMWr & access_ok;
        fault_sticky_d = fault_sticky_q | Fault;
    end

    // Store merge: replicate the store data across lanes and keep unselected bytes
    always_comb begin
        byte_en = 4'b0000;
        wr_data = DataWr;
        case (DMCtrl[1:0])
            2'b00: begin
                byte_en = 4'b0001 << Address[1:0];
                wr_data = {4{DataWr[7:0]}};
            end
            2'b01: begin
                byte_en = Address[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{DataWr[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
        wr_word_d = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) wr_word_d[8*i +: 8] = wr_data[8*i +: 8];
        end
    end

    // Storage and sticky flag; reset clears every word and wins over a same-cycle store
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
            fault_sticky_q <= 1'b0;
        end else begin
            if (wr_en) mem_q[word_idx] <= wr_word_d;
            fault_sticky_q <= fault_sticky_d;
        end
    end

    assign FaultSticky = fault_sticky_q;

    dm_load_align u_load_align (
        .word_in   (rd_word),
        .addr_lo   (Address[1:0]),
        .dmctrl    (DMCtrl),
        .access_ok (access_ok),
        .data_rd   (DataRd)
    );

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: each step pushes its expected outputs to a scoreboard
// queue, then pops and compares them once the combinational outputs have settled.
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic        DMWr;
    logic        DMRd;
    logic [2:0]  DMCtrl;
    logic [31:0] DataRd;
    logic        Fault;
    logic        FaultSticky;

    typedef struct {
        string       tag;
        int          which;   // 0 DataRd, 1 Fault, 2 FaultSticky
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic sticky_model;

    data_memory #(.DEPTH_WORDS(256)) dut (
        .clk         (clk),
        .rst         (rst),
        .Address     (Address),
        .DataWr      (DataWr),
        .DMWr        (DMWr),
        .DMRd        (DMRd),
        .DMCtrl      (DMCtrl),
        .DataRd      (DataRd),
        .Fault       (Fault),
        .FaultSticky (FaultSticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.which)
                0:       obs = DataRd;
                1:       obs = {31'd0, Fault};
                default: obs = {31'd0, FaultSticky};
            endcase
            vectors++;
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: got %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    // One cycle of stimulus, driven on the falling edge and checked 1ns later
    task automatic step(input string tag, input logic rst_v, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic wr, input logic rd,
                        input logic [2:0] ctrl, input logic [31:0] exp_rd, input logic exp_fault);
        @(negedge clk);
        rst     = rst_v;
        Address = addr;
        DataWr  = wdata;
        DMWr    = wr;
        DMRd    = rd;
        DMCtrl  = ctrl;
        sb.push_back('{{tag, ".rd"},     0, exp_rd});
        sb.push_back('{{tag, ".fault"},  1, {31'd0, exp_fault}});
        sb.push_back('{{tag, ".sticky"}, 2, {31'd0, sticky_model}});
        #1;
        drain();
        if (rst_v)          sticky_model = 1'b0;
        else if (exp_fault) sticky_model = 1'b1;
    endtask

    initial begin
        rst = 1'b1; Address = '0; DataWr = '0; DMWr = 1'b0; DMRd = 1'b0; DMCtrl = 3'b010;
        sticky_model = 1'b0;
        repeat (2) @(posedge clk);

        // Zero contents after reset
        step("lw0",     0, 32'h0,   0, 0, 1, 3'b010, 32'h0, 0);
        step("lw10",    0, 32'h10,  0, 0, 1, 3'b010, 32'h0, 0);
        step("lw3fc",   0, 32'h3FC, 0, 0, 1, 3'b010, 32'h0, 0);

        // Sign/zero extension
        step("sw8",     0, 32'h8, 32'h8000_00F0, 1, 0, 3'b010, 32'h0, 0);
        step("lb8",     0, 32'h8, 0, 0, 1, 3'b000, 32'hFFFF_FFF0, 0);
        step("lbu8",    0, 32'h8, 0, 0, 1, 3'b100, 32'h0000_00F0, 0);
        step("lha",     0, 32'hA, 0, 0, 1, 3'b001, 32'hFFFF_8000, 0);
        step("lhua",    0, 32'hA, 0, 0, 1, 3'b101, 32'h0000_8000, 0);

        // Partial-word merge; the SB cycle also shows the old byte (read-during-write)
        step("sw4",     0, 32'h4, 32'h1122_3344, 1, 0, 3'b010, 32'h0, 0);
        step("sb5",     0, 32'h5, 32'hFFFF_FFAB, 1, 0, 3'b000, 32'h0000_0033, 0);
        step("sh6",     0, 32'h6, 32'h1234_BEEF, 1, 1, 3'b001, 32'h0000_1122, 0);
        step("lw4",     0, 32'h4, 0, 0, 1, 3'b010, 32'hBEEF_AB44, 0);

        // Misaligned store, sticky flag, misaligned load
        step("swmis",   0, 32'h2, 32'hDEAD_BEEF, 1, 0, 3'b010, 32'h0, 1);
        step("lw0b",    0, 32'h0, 0, 0, 1, 3'b010, 32'h0, 0);
        step("lhmis",   0, 32'h1, 0, 0, 1, 3'b001, 32'h0, 1);
        step("lwnord",  0, 32'h2, 0, 0, 0, 3'b010, 32'h0, 0);

        // Illegal encodings: load 011, store with an unsigned width
        step("ld011",   0, 32'h4, 0, 0, 1, 3'b011, 32'h0, 1);
        step("sbuill",  0, 32'h4, 32'h0, 1, 0, 3'b100, 32'h0, 1);
        step("lw4b",    0, 32'h4, 0, 0, 1, 3'b010, 32'hBEEF_AB44, 0);

        // Address wrap
        step("sw400",   0, 32'h400, 32'h5, 1, 0, 3'b010, 32'h0, 0);
        step("lw0wrap", 0, 32'h0,   0, 0, 1, 3'b010, 32'h5, 0);

        // Reset beats a same-cycle store; first post-reset write lands
        step("swrst",   1, 32'hC,  32'h1234_5678, 1, 0, 3'b010, 32'h0, 0);
        step("swpost",  0, 32'h10, 32'hCAFE_F00D, 1, 0, 3'b010, 32'h0, 0);
        step("lwc",     0, 32'hC,  0, 0, 1, 3'b010, 32'h0, 0);
        step("lw0rst",  0, 32'h0,  0, 0, 1, 3'b010, 32'h0, 0);
        step("lw4rst",  0, 32'h4,  0, 0, 1, 3'b010, 32'h0, 0);
        step("lw10b",   0, 32'h10, 0, 0, 1, 3'b010, 32'hCAFE_F00D, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
